vga_timing_gen: RTL and testbench
=================================

// Module: vga_timing_gen
// PURPOSE
//  Source end of the VGA bus. Generates hcount/vcount, hsync/vsync and hblnk/vblnk, packs them with
//  rgb onto vga_out (VGA_BUS_SIZE), and feeds the first overlay stage of the draw pipeline.
//  Also emits a start-of-frame pulse and a frame counter for sprite/game-state updates.
//  Default timing: 1024x768@60 with pclk = 65 MHz.
// PARAMETERS
//  H_ACTIVE 1024 visible pixels per line
//  H_FP     24   horizontal front porch, pixels
//  H_SYNC   136  hsync width, pixels
//  H_BP     160  horizontal back porch, pixels; H_TOTAL = sum = 1344
//  V_ACTIVE 768  visible lines
//  V_FP     3    vertical front porch, lines
//  V_SYNC   6    vsync width, lines
//  V_BP     29   vertical back porch, lines; V_TOTAL = sum = 806
//  SYNC_POL 0    sync active level on the bus (0 = active-low)
// PORTS
//  pclk      in  1             pixel clock
//  rst_n     in  1             async reset, active-low
//  en        in  1             advance timing; low = freeze
//  vga_out   out VGA_BUS_SIZE  {hcount[10:0],hsync,hblnk,vcount[10:0],vsync,vblnk,rgb[11:0]}
//  sof       out 1             one-cycle pulse when bus enters (0,0) by wrap
//  frame_cnt out 8             frames completed, modulo 256
// BEHAVIOUR
//  - All outputs are registered. Sync, blank and rgb are decoded from the next-count values,
//    so each is aligned with the hcount/vcount shown on the same cycle.
//  - Reset (async, immediate, also mid-frame):
//      hcount=0, vcount=0, hblnk=0, vblnk=0, rgb=0, sof=0, frame_cnt=0.
//      hsync and vsync are driven to the inactive level (!SYNC_POL).
//  - en=1, per cycle:
//      hcount increments. At H_TOTAL-1 it wraps to 0.
//      On that same wrap cycle, vcount increments; at V_TOTAL-1 it wraps to 0.
//  - en=0: all outputs hold their value, including sof. sof stays high if it was high.
//  - hblnk = hcount >= H_ACTIVE
//  - hsync active while H_ACTIVE+H_FP <= hcount < H_ACTIVE+H_FP+H_SYNC
//  - vblnk = vcount >= V_ACTIVE
//  - vsync active while V_ACTIVE+V_FP <= vcount < V_ACTIVE+V_FP+V_SYNC. It is a whole-line
//    signal and changes on the hcount 0 transitions.
//  - Simultaneous wrap (hcount=H_TOTAL-1, vcount=V_TOTAL-1): both counters go to 0 on the
//    next cycle, and on that same cycle sof=1 and frame_cnt increments (255->0 wraps).
//  - The (0,0) state left by reset does not raise sof or count a frame. The first sof comes
//    one full frame (H_TOTAL*V_TOTAL enabled cycles) after reset release.
//  - Latency: fixed. Bus state after N enabled cycles is f(N mod H_TOTAL*V_TOTAL).
//  - Arithmetic: counters are 11-bit unsigned. Elaboration fails ($error) if H_TOTAL or
//    V_TOTAL > 2048, or if any porch or sync parameter is 0.
// CONFIGURATION
//  VGA_TEST_PATTERN_EN defined:
//    rgb = 8 vertical colour bars, index = hcount[9:7].
//    Colours: 000,00F,0F0,0FF,F00,F0F,FF0,FFF.
//    rgb is forced to 000 whenever hblnk or vblnk is high.
//  VGA_TEST_PATTERN_EN undefined: rgb = 12'h000 always; downstream stages paint background.
// STRUCTURE
//  - Bus width, field offsets and VGA_SPLIT/MERGE helpers come from the shared header
//    verilog_macro_bus.vh.
//  - Default 1024x768 timing constants go in the same shared header, so overlay stages can
//    use H_ACTIVE/V_ACTIVE.
//  - One sub-module: vga_counter (parameterised modulo counter with en, wrap flag output).
//    It is instantiated twice: horizontal, and vertical with en = h_wrap & en.
//  - Sync/blank/pattern decode and output registers stay in the top module.
// TESTING
//  1. Hold rst_n=0, then release -> bus all 0, syncs inactive, frame_cnt=0.
//     The first sof arrives exactly 1344*806 cycles after release.
//  2. Free-run one line -> hblnk rises at hcount=1024.
//     hsync low at hcount 1048..1183 only; next line starts after exactly 1344 cycles.
//  3. Run to vcount 805, hcount 1343 -> next cycle (0,0), sof=1 for 1 cycle, frame_cnt +1.
//     vsync low on lines 771..776 only.
//  4. Run 256 frames -> frame_cnt wraps 255->0 with the sof pulse; no missed or extra pulses.
//  5. Drop en for 50 cycles mid-line, then at (1343,805) -> outputs frozen, no sof while low.
//     Wrap and sof occur on the first enabled cycle after en returns.
//  6. Pulse rst_n low mid-frame at (500,300) -> bus clears asynchronously, before the next edge.
//     With VGA_TEST_PATTERN_EN: rgb=F00 at hcount 512..639 on visible lines, 000 when blanked.

Source files
------------

// File: rtl/vga_timing_gen_pkg.sv
// -----------------------------------------------------------------------------
// vga_timing_gen_pkg
//   Shared definitions for the VGA bus and its producers/consumers:
//     - counter and colour widths, total bus width (VGA_BUS_SIZE)
//     - default 1024x768@60 timing (65 MHz pixel clock), so overlay stages can
//       size themselves from the same H/V active constants
//     - vga_bus_t: packed view of the bus; first field is the MSB, giving
//       {hcount[10:0],hsync,hblnk,vcount[10:0],vsync,vblnk,rgb[11:0]}
//     - bar_colour(): colour of one of the 8 test-pattern bars
// -----------------------------------------------------------------------------
package vga_timing_gen_pkg;

  localparam int CNT_W        = 11;
  localparam int RGB_W        = 12;
  localparam int VGA_BUS_SIZE = 2 * CNT_W + 4 + RGB_W;  // 38 bits

  // Default 1024x768@60 timing.
  localparam int H_ACTIVE_DEF = 1024;
  localparam int H_FP_DEF     = 24;
  localparam int H_SYNC_DEF   = 136;
  localparam int H_BP_DEF     = 160;
  localparam int V_ACTIVE_DEF = 768;
  localparam int V_FP_DEF     = 3;
  localparam int V_SYNC_DEF   = 6;
  localparam int V_BP_DEF     = 29;

  typedef struct packed {
    logic [CNT_W-1:0] hcount;
    logic             hsync;
    logic             hblnk;
    logic [CNT_W-1:0] vcount;
    logic             vsync;
    logic             vblnk;
    logic [RGB_W-1:0] rgb;
  } vga_bus_t;

  // Bar i: bit 2 -> red, bit 1 -> green, bit 0 -> blue, each fully on or off.
  // Gives 000,00F,0F0,0FF,F00,F0F,FF0,FFF for i = 0..7.
  function automatic logic [RGB_W-1:0] bar_colour(input logic [2:0] idx);
    return {{4{idx[2]}}, {4{idx[1]}}, {4{idx[0]}}};
  endfunction

endpackage

// File: rtl/vga_timing_gen_counter.sv
// -----------------------------------------------------------------------------
// vga_counter
//   Modulo-MODULUS up-counter with enable. Used for both the horizontal
//   (pixel) and vertical (line) positions of vga_timing_gen.
// Ports
//   clk        in   clock
//   rst_n      in   async reset, active-low; count returns to 0
//   en         in   advance by one (wrapping at MODULUS-1) when high
//   count      out  current count (registered)
//   count_next out  value count takes on the next edge (combinational)
//   wrap       out  count is at MODULUS-1, i.e. an enabled cycle will wrap
// -----------------------------------------------------------------------------
module vga_counter
  import vga_timing_gen_pkg::*;
#(
  parameter int MODULUS = 1344
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  output logic [CNT_W-1:0] count,
  output logic [CNT_W-1:0] count_next,
  output logic             wrap
);

  localparam logic [CNT_W-1:0] COUNT_MAX = CNT_W'(MODULUS - 1);

  logic [CNT_W-1:0] count_q;
  logic [CNT_W-1:0] count_d;

  // NOTE: every signal assigned in always_comb gets a default first, so no
  // path leaves it unassigned and no latch is inferred.
  always_comb begin
    wrap    = (count_q == COUNT_MAX);
    count_d = count_q;
    if (en) begin
      count_d = wrap ? '0 : count_q + CNT_W'(1);
    end
  end

  // NOTE: sequential state uses non-blocking assignments only, so every flop
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count      = count_q;
  assign count_next = count_d;

endmodule

// File: rtl/vga_timing_gen.sv
// -----------------------------------------------------------------------------
// vga_timing_gen
//   Source end of the VGA bus. Generates pixel/line counters, sync and blank
//   strobes, an optional colour-bar test pattern, a start-of-frame pulse and a
//   frame counter. All outputs are registered; sync/blank/rgb are decoded from
//   the counters' next values so they line up with the hcount/vcount shown on
//   the same cycle.
// Ports
//   pclk      in   pixel clock
//   rst_n     in   async reset, active-low (clears bus, syncs go inactive)
//   en        in   advance timing; low freezes every output, sof included
//   vga_out   out  {hcount,hsync,hblnk,vcount,vsync,vblnk,rgb}
//   sof       out  one-cycle pulse when the counters wrap into (0,0)
//   frame_cnt out  completed frames, modulo 256
// Configuration
//   VGA_TEST_PATTERN_EN  when defined, rgb shows 8 vertical colour bars
//                        (index hcount[9:7]) and is black while blanked;
//                        otherwise rgb is always 12'h000.
// -----------------------------------------------------------------------------
module vga_timing_gen
  import vga_timing_gen_pkg::*;
#(
  parameter int   H_ACTIVE = H_ACTIVE_DEF,
  parameter int   H_FP     = H_FP_DEF,
  parameter int   H_SYNC   = H_SYNC_DEF,
  parameter int   H_BP     = H_BP_DEF,
  parameter int   V_ACTIVE = V_ACTIVE_DEF,
  parameter int   V_FP     = V_FP_DEF,
  parameter int   V_SYNC   = V_SYNC_DEF,
  parameter int   V_BP     = V_BP_DEF,
  parameter logic SYNC_POL = 1'b0
) (
  input  logic                    pclk,
  input  logic                    rst_n,
  input  logic                    en,
  output logic [VGA_BUS_SIZE-1:0] vga_out,
  output logic                    sof,
  output logic [7:0]              frame_cnt
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  // Decode thresholds, sized to the counters to keep comparisons width-exact.
  localparam logic [CNT_W-1:0] H_BLANK_START = CNT_W'(H_ACTIVE);
  localparam logic [CNT_W-1:0] H_SYNC_START  = CNT_W'(H_ACTIVE + H_FP);
  localparam logic [CNT_W-1:0] H_SYNC_END    = CNT_W'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [CNT_W-1:0] V_BLANK_START = CNT_W'(V_ACTIVE);
  localparam logic [CNT_W-1:0] V_SYNC_START  = CNT_W'(V_ACTIVE + V_FP);
  localparam logic [CNT_W-1:0] V_SYNC_END    = CNT_W'(V_ACTIVE + V_FP + V_SYNC);

  if (H_TOTAL > 2048 || V_TOTAL > 2048 ||
      H_FP == 0 || H_SYNC == 0 || H_BP == 0 ||
      V_FP == 0 || V_SYNC == 0 || V_BP == 0) begin : g_bad_timing
    $error("vga_timing_gen: totals must be <= 2048 and porch/sync widths non-zero");
  end

  // ---------------------------------------------------------------------------
  // Counters: the line counter only steps on the last pixel of a line.
  // ---------------------------------------------------------------------------
  logic [CNT_W-1:0] h_cnt, h_next;
  logic [CNT_W-1:0] v_cnt, v_next;
  logic             h_wrap, v_wrap;
  logic             frame_wrap;

  vga_counter #(.MODULUS(H_TOTAL)) u_hcnt (
    .clk        (pclk),
    .rst_n      (rst_n),
    .en         (en),
    .count      (h_cnt),
    .count_next (h_next),
    .wrap       (h_wrap)
  );

  vga_counter #(.MODULUS(V_TOTAL)) u_vcnt (
    .clk        (pclk),
    .rst_n      (rst_n),
    .en         (en & h_wrap),
    .count      (v_cnt),
    .count_next (v_next),
    .wrap       (v_wrap)
  );

  // Last pixel of the last line: the next enabled edge starts a new frame.
  assign frame_wrap = h_wrap & v_wrap;

  // ---------------------------------------------------------------------------
  // Decode from next counts. With en low the next counts equal the current
  // ones, so these registers hold without any extra enable logic.
  // ---------------------------------------------------------------------------
  logic             hsync_q, hsync_d;
  logic             hblnk_q, hblnk_d;
  logic             vsync_q, vsync_d;
  logic             vblnk_q, vblnk_d;
  logic [RGB_W-1:0] rgb_q, rgb_d;
  logic             sof_q, sof_d;
  logic [7:0]       frame_cnt_q, frame_cnt_d;

  always_comb begin
    hblnk_d = (h_next >= H_BLANK_START);
    vblnk_d = (v_next >= V_BLANK_START);
    hsync_d = (h_next >= H_SYNC_START && h_next < H_SYNC_END) ? SYNC_POL : ~SYNC_POL;
    // v_next only moves on a line wrap, so vsync changes with hcount -> 0.
    vsync_d = (v_next >= V_SYNC_START && v_next < V_SYNC_END) ? SYNC_POL : ~SYNC_POL;

`ifdef VGA_TEST_PATTERN_EN
    rgb_d = (hblnk_d || vblnk_d) ? '0 : bar_colour(h_next[9:7]);
`else
    rgb_d = '0;
`endif

    // sof reflects the last enabled edge, so it holds (possibly high) while en is low.
    sof_d       = sof_q;
    frame_cnt_d = frame_cnt_q;
    if (en) begin
      sof_d = frame_wrap;
      if (frame_wrap) begin
        frame_cnt_d = frame_cnt_q + 8'd1;
      end
    end
  end

  // NOTE: only real state is reset here; syncs reset to their inactive level
  // so the bus idles cleanly while rst_n is low.
  always_ff @(posedge pclk or negedge rst_n) begin
    if (!rst_n) begin
      hsync_q     <= ~SYNC_POL;
      hblnk_q     <= 1'b0;
      vsync_q     <= ~SYNC_POL;
      vblnk_q     <= 1'b0;
      rgb_q       <= '0;
      sof_q       <= 1'b0;
      frame_cnt_q <= 8'd0;
    end else begin
      hsync_q     <= hsync_d;
      hblnk_q     <= hblnk_d;
      vsync_q     <= vsync_d;
      vblnk_q     <= vblnk_d;
      rgb_q       <= rgb_d;
      sof_q       <= sof_d;
      frame_cnt_q <= frame_cnt_d;
    end
  end

  vga_bus_t bus;

  always_comb begin
    bus.hcount = h_cnt;
    bus.hsync  = hsync_q;
    bus.hblnk  = hblnk_q;
    bus.vcount = v_cnt;
    bus.vsync  = vsync_q;
    bus.vblnk  = vblnk_q;
    bus.rgb    = rgb_q;
  end

  assign vga_out   = bus;
  assign sof       = sof_q;
  assign frame_cnt = frame_cnt_q;

endmodule

// File: tb/tb_vga_timing_gen.sv
// -----------------------------------------------------------------------------
// tb_vga_timing_gen
//   Two instances share clock, reset and enable: one with the default
//   1024x768 timing (line-level checks) and one with a tiny 12x7 frame so that
//   whole frames and the 8-bit frame counter wrap fit in a short run.
//   The reference model derives every output purely from the number of
//   enabled cycles since reset, n: position = n mod frame size, frames =
//   n / frame size.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_vga_timing_gen;
  import vga_timing_gen_pkg::*;

  typedef struct {
    int ha, hf, hs, hb, va, vf, vs, vb;
  } timing_t;

  localparam timing_t BIG   = '{ha: 1024, hf: 24, hs: 136, hb: 160, va: 768, vf: 3, vs: 6, vb: 29};
  localparam timing_t SMALL = '{ha: 8, hf: 1, hs: 2, hb: 1, va: 4, vf: 1, vs: 1, vb: 1};
  localparam int SMALL_FRAME = 12 * 7;

  logic                    pclk = 1'b0;
  logic                    rst_n;
  logic                    en;
  logic [VGA_BUS_SIZE-1:0] vga_b, vga_s;
  logic                    sof_b, sof_s;
  logic [7:0]              frame_b, frame_s;

  int n;            // enabled cycles since last reset
  int vectors     = 0;
  int miscompares = 0;

  always #5 pclk = ~pclk;

  vga_timing_gen u_big (
    .pclk      (pclk),
    .rst_n     (rst_n),
    .en        (en),
    .vga_out   (vga_b),
    .sof       (sof_b),
    .frame_cnt (frame_b)
  );

  vga_timing_gen #(
    .H_ACTIVE (8), .H_FP (1), .H_SYNC (2), .H_BP (1),
    .V_ACTIVE (4), .V_FP (1), .V_SYNC (1), .V_BP (1)
  ) u_small (
    .pclk      (pclk),
    .rst_n     (rst_n),
    .en        (en),
    .vga_out   (vga_s),
    .sof       (sof_s),
    .frame_cnt (frame_s)
  );

  // ---------------------------------------------------------------------------
  // Reference model
  // ---------------------------------------------------------------------------
  function automatic logic [VGA_BUS_SIZE-1:0] model_bus(input int cycles, input timing_t t);
    int ht, vt, m, h, v;
    logic hsync, hblnk, vsync, vblnk;
    logic [11:0] rgb;
    logic [10:0] h11, v11;
    ht    = t.ha + t.hf + t.hs + t.hb;
    vt    = t.va + t.vf + t.vs + t.vb;
    m     = cycles % (ht * vt);
    h     = m % ht;
    v     = m / ht;
    hblnk = (h >= t.ha);
    vblnk = (v >= t.va);
    hsync = !(h >= t.ha + t.hf && h < t.ha + t.hf + t.hs);  // active-low
    vsync = !(v >= t.va + t.vf && v < t.va + t.vf + t.vs);
    rgb   = 12'h000;
`ifdef VGA_TEST_PATTERN_EN
    if (!hblnk && !vblnk) begin
      case ((h / 128) % 8)
        0: rgb = 12'h000;  1: rgb = 12'h00F;  2: rgb = 12'h0F0;  3: rgb = 12'h0FF;
        4: rgb = 12'hF00;  5: rgb = 12'hF0F;  6: rgb = 12'hFF0;  default: rgb = 12'hFFF;
      endcase
    end
`endif
    h11 = 11'(h);
    v11 = 11'(v);
    return {h11, hsync, hblnk, v11, vsync, vblnk, rgb};
  endfunction

  function automatic logic model_sof(input int cycles, input timing_t t);
    int ft;
    ft = (t.ha + t.hf + t.hs + t.hb) * (t.va + t.vf + t.vs + t.vb);
    return (cycles > 0) && (cycles % ft == 0);
  endfunction

  function automatic logic [7:0] model_frame(input int cycles, input timing_t t);
    int ft;
    ft = (t.ha + t.hf + t.hs + t.hb) * (t.va + t.vf + t.vs + t.vb);
    return 8'((cycles / ft) % 256);
  endfunction

  // ---------------------------------------------------------------------------
  // Checking helpers
  // ---------------------------------------------------------------------------
  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (n=%0d, t=%0t)", name, act, exp, n, $time);
    end
  endtask

  task automatic check_all();
    check("big.bus",     64'(vga_b),   64'(model_bus(n, BIG)));
    check("big.sof",     64'(sof_b),   64'(model_sof(n, BIG)));
    check("big.frame",   64'(frame_b), 64'(model_frame(n, BIG)));
    check("small.bus",   64'(vga_s),   64'(model_bus(n, SMALL)));
    check("small.sof",   64'(sof_s),   64'(model_sof(n, SMALL)));
    check("small.frame", 64'(frame_s), 64'(model_frame(n, SMALL)));
  endtask

  // One clock: model advances on enabled edges, outputs checked 1 ns later.
  task automatic tick();
    @(posedge pclk);
    if (rst_n && en) n++;
    #1;
    check_all();
  endtask

  task automatic do_reset();
    @(posedge pclk);
    #1;
    rst_n = 1'b0;
    en    = 1'b0;
    n     = 0;
    repeat (3) @(posedge pclk);
    #1;
    rst_n = 1'b1;
  endtask

  // Table vectors for the default-timing instance, applied cumulatively from reset.
  typedef struct {
    bit en;
    int cycles;
    int h;
    int v;
    bit hsync;
    bit hblnk;
    bit vsync;
    bit vblnk;
  } vec_t;

  vec_t tbl[11];
  localparam logic [VGA_BUS_SIZE-1:0] RESET_BUS = {11'd0, 1'b1, 1'b0, 11'd0, 1'b1, 1'b0, 12'h000};

  initial begin
    int cnt, f0, pulses, saw_wrap, prev_frame;
    logic [VGA_BUS_SIZE-1:0] bus_v;

    tbl[0]  = '{1, 0,    0,    0, 1, 0, 1, 0};
    tbl[1]  = '{1, 1023, 1023, 0, 1, 0, 1, 0};
    tbl[2]  = '{1, 1,    1024, 0, 1, 1, 1, 0};  // hblnk rises
    tbl[3]  = '{1, 23,   1047, 0, 1, 1, 1, 0};
    tbl[4]  = '{1, 1,    1048, 0, 0, 1, 1, 0};  // hsync asserts
    tbl[5]  = '{1, 135,  1183, 0, 0, 1, 1, 0};
    tbl[6]  = '{1, 1,    1184, 0, 1, 1, 1, 0};  // hsync releases
    tbl[7]  = '{1, 159,  1343, 0, 1, 1, 1, 0};
    tbl[8]  = '{1, 1,    0,    1, 1, 0, 1, 0};  // next line after 1344 cycles
    tbl[9]  = '{0, 50,   0,    1, 1, 0, 1, 0};  // frozen
    tbl[10] = '{1, 1,    1,    1, 1, 0, 1, 0};

    rst_n = 1'b0;
    en    = 1'b0;
    n     = 0;

    // --- Reset state ---------------------------------------------------------
    repeat (3) @(posedge pclk);
    #1;
    check("reset.big.bus",   64'(vga_b),   64'(RESET_BUS));
    check("reset.small.bus", 64'(vga_s),   64'(RESET_BUS));
    check("reset.sof",       64'(sof_s),   64'(0));
    check("reset.frame",     64'(frame_s), 64'(0));
    rst_n = 1'b1;

    // --- First sof exactly one frame after release ----------------------------
    en  = 1'b1;
    cnt = 0;
    while (sof_s !== 1'b1 && cnt < 4 * SMALL_FRAME) begin
      tick();
      cnt++;
    end
    check("first_sof.latency", 64'(cnt), 64'(SMALL_FRAME));
    check("first_sof.frame",   64'(frame_s), 64'(1));

    // --- Line-level table on the default timing ------------------------------
    do_reset();
    for (int i = 0; i < 11; i++) begin
      en = tbl[i].en;
      repeat (tbl[i].cycles) tick();
      bus_v = vga_b;
      check($sformatf("tbl%0d.hcount", i), 64'(bus_v[37:27]), 64'(tbl[i].h));
      check($sformatf("tbl%0d.hsync", i),  64'(bus_v[26]),    64'(tbl[i].hsync));
      check($sformatf("tbl%0d.hblnk", i),  64'(bus_v[25]),    64'(tbl[i].hblnk));
      check($sformatf("tbl%0d.vcount", i), 64'(bus_v[24:14]), 64'(tbl[i].v));
      check($sformatf("tbl%0d.vsync", i),  64'(bus_v[13]),    64'(tbl[i].vsync));
      check($sformatf("tbl%0d.vblnk", i),  64'(bus_v[12]),    64'(tbl[i].vblnk));
    end

    // --- Freeze at the last pixel of a frame, then wrap ------------------------
    en  = 1'b1;
    cnt = 0;
    while (n % SMALL_FRAME != SMALL_FRAME - 1 && cnt < 2 * SMALL_FRAME) begin
      tick();
      cnt++;
    end
    bus_v = vga_s;
    check("freeze.at_h_last", 64'(bus_v[37:27]), 64'(11));
    check("freeze.at_v_last", 64'(bus_v[24:14]), 64'(6));
    f0 = int'(frame_s);
    en = 1'b0;
    pulses = 0;
    repeat (50) begin
      tick();
      if (sof_s === 1'b1) pulses++;
    end
    check("freeze.no_sof", 64'(pulses), 64'(0));
    check("freeze.held_h", 64'(vga_s[37:27]), 64'(11));
    en = 1'b1;
    tick();
    check("wrap.sof",    64'(sof_s),         64'(1));
    check("wrap.hv",     64'({vga_s[37:27], vga_s[24:14]}), 64'(0));
    check("wrap.frame",  64'(frame_s),       64'((f0 + 1) % 256));
    // sof must hold while frozen, then drop on the next enabled edge.
    en = 1'b0;
    repeat (3) tick();
    check("wrap.sof_held", 64'(sof_s), 64'(1));
    en = 1'b1;
    tick();
    check("wrap.sof_drop", 64'(sof_s), 64'(0));

    // --- 256 frames: counter wraps through 255->0, one sof per frame -----------
    f0         = int'(frame_s);
    pulses     = 0;
    saw_wrap   = 0;
    prev_frame = f0;
    repeat (256 * SMALL_FRAME) begin
      tick();
      if (sof_s === 1'b1) pulses++;
      if (prev_frame == 255 && frame_s === 8'd0 && sof_s === 1'b1) saw_wrap = 1;
      prev_frame = int'(frame_s);
    end
    check("frames256.pulses", 64'(pulses),  64'(256));
    check("frames256.frame",  64'(frame_s), 64'(f0));
    check("frames256.wrap",   64'(saw_wrap), 64'(1));

    // --- Randomised enable against the model -----------------------------------
    repeat (3000) begin
      en = ($urandom_range(0, 3) != 0);
      tick();
    end

    // --- Asynchronous reset mid-frame -------------------------------------------
    en = 1'b1;
    repeat (500) tick();
    #2;
    rst_n = 1'b0;  // between edges
    #1;
    n = 0;
    check("async_rst.big.bus",   64'(vga_b),   64'(RESET_BUS));
    check("async_rst.small.bus", 64'(vga_s),   64'(RESET_BUS));
    check("async_rst.frame",     64'(frame_s), 64'(0));
    check("async_rst.sof",       64'(sof_s),   64'(0));
    @(posedge pclk);
    #3;
    rst_n = 1'b1;
    repeat (200) tick();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
